// File: rtl/line_follow_cntrl.sv
// line_follow_cntrl: scans IR sensor pairs through a shared A2D and runs a PI
// steering loop that turns the left/right imbalance into signed motor commands.
module line_follow_cntrl #(
    parameter int          NUM_PAIRS  = 3,
    parameter int          SETTLE_CYC = 4096,
    parameter int          ACQ_CYC    = 32,
    parameter logic [13:0] P_TERM     = 14'h3680,
    parameter logic [11:0] I_TERM     = 12'h500,
    parameter logic [11:0] FWD_MAX    = 12'h700,
    parameter logic [7:0]  IR_DUTY    = 8'h8C
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    output logic                   strt_cnv,
    output logic [2:0]             chnnl,
    input  logic                   cnv_cmplt,
    input  logic [11:0]            A2D_res,
    output logic [NUM_PAIRS-1:0]   IR_en,
    output logic signed [10:0]     lft,
    output logic signed [10:0]     rht
);
    typedef enum logic [2:0] {IDLE, SETTLE, CONV_L, ACQ, CONV_R, NEXT, PI_UPD} state_t;

    state_t             state;
    logic [1:0]         pair;
    logic [15:0]        tmr;
    logic [7:0]         pwm_cnt;
    logic [1:0]         int_dec;
    logic [11:0]        fwd, fwd_nxt;
    logic signed [15:0] accum, res_sh, l_sum, r_sum;
    logic signed [11:0] error, intgrl, intgrl_sat, intgrl_nxt;
    logic signed [12:0] i_sum;
    logic signed [26:0] pprod;
    logic signed [24:0] iprod;
    logic signed [13:0] pcomp, icomp;
    logic               pwm;

    function automatic logic signed [10:0] sat11(input logic signed [15:0] v);
        return (v > 16'sd1023) ? 11'sd1023 : (v < -16'sd1024) ? -11'sd1024 : v[10:0];
    endfunction

    // far pairs are weighted more heavily so a drifting line pulls harder
    assign res_sh     = $signed({4'b0, A2D_res} << pair);
    assign pwm        = pwm_cnt < IR_DUTY;
    assign error      = (accum > 16'sd2047) ? 12'sd2047 : (accum < -16'sd2048) ? -12'sd2048 : accum[11:0];
    assign i_sum      = 13'(intgrl) + 13'(error >>> 4);
    assign intgrl_sat = (i_sum > 13'sd2047) ? 12'sd2047 : (i_sum < -13'sd2048) ? -12'sd2048 : i_sum[11:0];
    assign intgrl_nxt = (int_dec == 2'd3) ? intgrl_sat : intgrl;
    assign fwd_nxt    = (fwd < FWD_MAX) ? fwd + 12'd1 : fwd;
    assign pprod      = 27'(error) * 27'($signed({1'b0, P_TERM}));
    assign iprod      = 25'(intgrl_nxt) * 25'($signed({1'b0, I_TERM}));
    assign pcomp      = pprod[26:13];
    assign icomp      = iprod[24:11];
    assign l_sum      = $signed({4'b0, fwd_nxt}) + 16'(pcomp) + 16'(icomp);
    assign r_sum      = $signed({4'b0, fwd_nxt}) - 16'(pcomp) - 16'(icomp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pair     <= '0;
            tmr      <= '0;
            pwm_cnt  <= '0;
            int_dec  <= '0;
            fwd      <= '0;
            accum    <= '0;
            intgrl   <= '0;
            strt_cnv <= 1'b0;
            chnnl    <= '0;
            IR_en    <= '0;
            lft      <= '0;
            rht      <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + 8'd1;
            strt_cnv <= 1'b0;
            IR_en    <= (state inside {SETTLE, CONV_L, ACQ, CONV_R}) ? NUM_PAIRS'(pwm) << pair : '0;
            if (!go) begin
                fwd    <= '0;
                intgrl <= '0;
                lft    <= '0;
                rht    <= '0;
            end
            case (state)
                IDLE: begin
                    state <= SETTLE;
                    pair  <= '0;
                    accum <= '0;
                    tmr   <= '0;
                end
                SETTLE: begin
                    tmr <= (tmr == 16'(SETTLE_CYC - 1)) ? '0 : tmr + 16'd1;
                    if (tmr == 16'(SETTLE_CYC - 1)) begin
                        strt_cnv <= 1'b1;
                        chnnl    <= {pair, 1'b0};
                        state    <= CONV_L;
                    end
                end
                CONV_L: if (cnv_cmplt) begin
                    accum <= accum + res_sh;
                    state <= ACQ;
                end
                ACQ: begin
                    tmr <= (tmr == 16'(ACQ_CYC - 1)) ? '0 : tmr + 16'd1;
                    if (tmr == 16'(ACQ_CYC - 1)) begin
                        strt_cnv <= 1'b1;
                        chnnl    <= {pair, 1'b1};
                        state    <= CONV_R;
                    end
                end
                CONV_R: if (cnv_cmplt) begin
                    accum <= accum - res_sh;
                    state <= NEXT;
                end
                NEXT: begin
                    pair  <= (pair == 2'(NUM_PAIRS - 1)) ? pair : pair + 2'd1;
                    state <= (pair == 2'(NUM_PAIRS - 1)) ? PI_UPD : SETTLE;
                end
                PI_UPD: begin
                    int_dec <= int_dec + 2'd1;
                    state   <= IDLE;
                    if (go) begin
                        fwd    <= fwd_nxt;
                        intgrl <= intgrl_nxt;
                        lft    <= sat11(l_sum);
                        rht    <= sat11(r_sum);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_follow_cntrl.sv
// tb_line_follow_cntrl: randomized A2D responder feeding a scoreboard; a monitor
// compares lft/rht at each new scan start against a behavioural PI model.
module tb_line_follow_cntrl;
    localparam int          NP   = 3;
    localparam int          SC   = 20;
    localparam int          AC   = 5;
    localparam int          FMAX = 16;
    localparam int          PT   = 'h3680;
    localparam int          IT   = 'h500;

    logic clk = 0, rst, go, strt_cnv, cnv_cmplt;
    logic [2:0] chnnl;
    logic [11:0] A2D_res;
    logic [NP-1:0] IR_en;
    logic signed [10:0] lft, rht;

    line_follow_cntrl #(.NUM_PAIRS(NP), .SETTLE_CYC(SC), .ACQ_CYC(AC), .FWD_MAX(12'(FMAX))) dut (
        .clk(clk), .rst(rst), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_en(IR_en), .lft(lft), .rht(rht)
    );

    always #5 clk = ~clk;

    typedef struct {int l; int r;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int m_fwd = 0, m_intg = 0, m_cnt = 0;
    int res[6];
    int exp_ch = 0, t_done = 0;
    bit have_gap = 0, park = 0, parked = 0, dir_scan = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // one PI update from the six conversions of a full scan
    function automatic exp_t model_update(input bit g);
        int acc = 0, err, p, i;
        exp_t e;
        for (int k = 0; k < NP; k++) acc += (res[2*k] - res[2*k+1]) * (1 << k);
        err = clamp(acc, -2048, 2047);
        if (!g) begin
            m_fwd = 0;
            m_intg = 0;
        end else begin
            if (m_cnt == 3) m_intg = clamp(m_intg + (err >>> 4), -2048, 2047);
            if (m_fwd < FMAX) m_fwd++;
        end
        m_cnt = (m_cnt + 1) % 4;
        p = (err * PT) >>> 13;
        i = (m_intg * IT) >>> 11;
        e.l = g ? clamp(m_fwd + p + i, -1024, 1023) : 0;
        e.r = g ? clamp(m_fwd - p - i, -1024, 1023) : 0;
        return e;
    endfunction

    // A2D responder: answers each conversion after a random delay
    initial begin
        int dly, v, ch;
        forever begin
            @(negedge clk);
            if (!rst && strt_cnv) begin
                ch = chnnl;
                check("chnnl_order", ch, exp_ch);
                if (have_gap) check("cnv_gap", cyc - t_done, (ch % 2) ? AC : (ch == 0 ? SC + 3 : SC + 1));
                if (park && ch == 1) parked = 1;
                else begin
                    dly = $urandom_range(1, 6);
                    for (int d = 0; d < dly; d++) begin
                        @(negedge clk);
                        check("chnnl_stable", chnnl, ch);
                        check("no_strt_busy", strt_cnv, 0);
                        check("ir_en_pair", int'(IR_en) & ~(1 << (ch / 2)), 0);
                    end
                    v = dir_scan ? ((ch % 2) ? 0 : 'h100) :
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : 'h800 + $urandom_range(0, 127) - 64;
                    res[ch] = v;
                    A2D_res = 12'(v);
                    cnv_cmplt = 1;
                    @(negedge clk);
                    cnv_cmplt = 0;
                    t_done = cyc;
                    have_gap = 1;
                    if (ch == 2 * NP - 1) sb.push_back(model_update(go));
                    exp_ch = (ch + 1) % (2 * NP);
                end
            end
        end
    end

    // monitor: a fresh scan start means the previous PI update is visible
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && strt_cnv && chnnl == 0 && sb.size() > 0) begin
                e = sb.pop_front();
                check("lft", lft, e.l);
                check("rht", rht, e.r);
            end
        end
    end

    task automatic wait_scan();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(strt_cnv && chnnl == 0) && n < 2000);
        if (n >= 2000) check("scan_timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst = 1; go = 0; cnv_cmplt = 0; A2D_res = 0;
        repeat (3) @(negedge clk);
        check("rst_strt", strt_cnv, 0);
        check("rst_chnnl", chnnl, 0);
        check("rst_ir", IR_en, 0);
        check("rst_lft", lft, 0);
        check("rst_rht", rht, 0);
        rst = 0;
        go = 1;
        for (int s = 0; s < 10; s++) begin
            wait_scan();
            go = ($urandom_range(0, 4) != 0);
        end
        wait_scan();
        go = 1;
        dir_scan = 1;
        wait_scan();
        dir_scan = 0;
        repeat (22) wait_scan();
        go = 0;
        @(negedge clk);
        check("go_drop_lft", lft, 0);
        check("go_drop_rht", rht, 0);
        wait_scan();
        go = 1;
        repeat (3) wait_scan();
        park = 1;
        n = 0;
        while (!parked && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!parked) check("park_timeout", 1, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("mid_rst_strt", strt_cnv, 0);
        check("mid_rst_chnnl", chnnl, 0);
        check("mid_rst_ir", IR_en, 0);
        check("mid_rst_lft", lft, 0);
        check("mid_rst_rht", rht, 0);
        sb.delete();
        m_fwd = 0; m_intg = 0; m_cnt = 0;
        exp_ch = 0; have_gap = 0; park = 0; parked = 0;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        A2D_res = 12'hFFF;
        cnv_cmplt = 1;
        @(negedge clk);
        cnv_cmplt = 0;
        wait_scan();
        check("post_rst_lft", lft, 0);
        check("post_rst_rht", rht, 0);
        repeat (4) wait_scan();
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
